fetch_predictor: RTL and testbench

FETCH_PREDICTOR -- requirements
Module: fetch_predictor

---
 rtl/fetch_predictor.sv | 178 +++++++++++++++++
 tb/tb_fetch_predictor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_predictor.sv
// Fetch PC register with an optional fully associative BTB and per-entry history counters.
// Define FETCH_BTB_EN to build the BTB; without it the next PC is redirect > stall > PC+4.
module fetch_predictor #(
    parameter int          B_N      = 16,
    parameter int          b_h      = 2,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [63:0] PCTargetE,
    input  logic        UpdValidE,
    input  logic        UpdTakenE,
    input  logic [63:0] UpdPCE,
    input  logic [63:0] UpdTargetE,
    output logic [63:0] PCF,
    output logic [63:0] PCNextF,
    output logic        PredTakenF
);

    logic [63:0] pc_q;
    logic [63:0] pc_next;
    logic        pred_taken;
    logic        btb_pred;
    logic [63:0] btb_target;

`ifdef FETCH_BTB_EN
    localparam int             IW       = $clog2(B_N);
    localparam logic [b_h-1:0] CTR_MAX  = '1;
    localparam logic [b_h-1:0] CTR_WEAK = b_h'(1) << (b_h - 1);

    logic [B_N-1:0] valid_q;
    logic [63:0]    bia_q [B_N];
    logic [63:0]    bta_q [B_N];
    logic [b_h-1:0] ctr_q [B_N];
    logic [IW-1:0]  rr_q;

    logic          f_hit;
    logic [IW-1:0] f_idx;
    logic          u_hit;
    logic [IW-1:0] u_idx;
    logic          any_free;
    logic [IW-1:0] free_idx;

    // Scanning from the top down leaves the lowest matching index in each result.
    always_comb begin
        f_hit    = 1'b0;
        f_idx    = '0;
        u_hit    = 1'b0;
        u_idx    = '0;
        any_free = 1'b0;
        free_idx = '0;
        for (int i = B_N - 1; i >= 0; i--) begin
            if (valid_q[i] && (bia_q[i] == pc_q)) begin
                f_hit = 1'b1;
                f_idx = IW'(i);
            end
            if (valid_q[i] && (bia_q[i] == UpdPCE)) begin
                u_hit = 1'b1;
                u_idx = IW'(i);
            end
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign btb_pred   = f_hit && ctr_q[f_idx][b_h-1];
    assign btb_target = bta_q[f_idx];

    logic           wr_en;
    logic           wr_valid;
    logic           wr_bia;
    logic           wr_bta;
    logic           rr_adv;
    logic [IW-1:0]  wr_idx;
    logic [b_h-1:0] wr_ctr;

    always_comb begin
        wr_en    = 1'b0;
        wr_valid = 1'b0;
        wr_bia   = 1'b0;
        wr_bta   = 1'b0;
        rr_adv   = 1'b0;
        wr_idx   = u_idx;
        wr_ctr   = ctr_q[u_idx];
        if (UpdValidE) begin
            if (u_hit) begin
                wr_en = 1'b1;
                if (UpdTakenE) begin
                    wr_valid = 1'b1;
                    wr_bta   = 1'b1;
                    wr_ctr   = (ctr_q[u_idx] == CTR_MAX) ? CTR_MAX : ctr_q[u_idx] + b_h'(1);
                end else if (ctr_q[u_idx] <= b_h'(1)) begin
                    wr_valid = 1'b0;
                    wr_ctr   = '0;
                end else begin
                    wr_valid = 1'b1;
                    wr_ctr   = ctr_q[u_idx] - b_h'(1);
                end
            end else if (UpdTakenE) begin
                wr_en    = 1'b1;
                wr_valid = 1'b1;
                wr_bia   = 1'b1;
                wr_bta   = 1'b1;
                wr_ctr   = CTR_WEAK;
                if (any_free) begin
                    wr_idx = free_idx;
                end else begin
                    wr_idx = rr_q;
                    rr_adv = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            rr_q    <= '0;
            for (int i = 0; i < B_N; i++) begin
                ctr_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                valid_q[wr_idx] <= wr_valid;
                ctr_q[wr_idx]   <= wr_ctr;
            end
            if (rr_adv) begin
                rr_q <= rr_q + IW'(1);
            end
        end
    end

    // Tag/target payload is meaningless until Valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_bia) begin
            bia_q[wr_idx] <= UpdPCE;
        end
        if (!rst && wr_bta) begin
            bta_q[wr_idx] <= UpdTargetE;
        end
    end
`else
    logic unused_upd;
    assign unused_upd = ^{UpdValidE, UpdTakenE, UpdPCE, UpdTargetE, 32'(B_N), 32'(b_h)};
    assign btb_pred   = 1'b0;
    assign btb_target = '0;
`endif

    always_comb begin
        pc_next    = pc_q + 64'd4;
        pred_taken = 1'b0;
        if (PCSrcE) begin
            pc_next = PCTargetE;
        end else if (StallF) begin
            pc_next = pc_q;
        end else if (btb_pred) begin
            pc_next    = btb_target;
            pred_taken = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign PCF        = pc_q;
    assign PCNextF    = pc_next;
    assign PredTakenF = pred_taken;

endmodule

// File: tb/tb_fetch_predictor.sv
// Directed bench for fetch_predictor (B_N=4, b_h=2, RESET_PC=0x1000); expectations follow FETCH_BTB_EN.
module tb_fetch_predictor;

`ifdef FETCH_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallF = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [63:0] PCTargetE = '0;
    logic        UpdValidE = 1'b0;
    logic        UpdTakenE = 1'b0;
    logic [63:0] UpdPCE = '0;
    logic [63:0] UpdTargetE = '0;
    logic [63:0] PCF;
    logic [63:0] PCNextF;
    logic        PredTakenF;

    int checks   = 0;
    int failures = 0;

    fetch_predictor #(.B_N(4), .b_h(2), .RESET_PC(64'h1000)) dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .UpdValidE  (UpdValidE),
        .UpdTakenE  (UpdTakenE),
        .UpdPCE     (UpdPCE),
        .UpdTargetE (UpdTargetE),
        .PCF        (PCF),
        .PCNextF    (PCNextF),
        .PredTakenF (PredTakenF)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_next(input logic [63:0] p, input logic [63:0] tgt, input bit taken);
        return (BTB && taken) ? tgt : p + 64'd4;
    endfunction

    // Redirect the fetch to p, then check the fetch of p; taken means the BTB should predict tgt.
    task automatic fetch(input string tag, input logic [63:0] p, input logic [63:0] tgt, input bit taken);
        PCSrcE    = 1'b1;
        PCTargetE = p;
        tick();
        PCSrcE    = 1'b0;
        PCTargetE = '0;
        #1;
        chk64({tag, "_pcf"}, PCF, p);
        chk64({tag, "_next"}, PCNextF, exp_next(p, tgt, taken));
        chk1({tag, "_pred"}, PredTakenF, BTB && taken);
    endtask

    task automatic upd(input logic [63:0] pc, input logic [63:0] tgt, input bit taken);
        UpdValidE  = 1'b1;
        UpdTakenE  = taken;
        UpdPCE     = pc;
        UpdTargetE = tgt;
        tick();
        UpdValidE  = 1'b0;
        UpdTakenE  = 1'b0;
    endtask

    initial begin
        // Reset then free run
        repeat (2) tick();
        chk64("rst_pcf", PCF, 64'h1000);
        chk1("rst_pred", PredTakenF, 1'b0);
        rst = 1'b0;
        #1;
        chk64("run_pcf0", PCF, 64'h1000);
        chk64("run_next0", PCNextF, 64'h1004);
        chk1("run_pred0", PredTakenF, 1'b0);
        tick();
        chk64("run_pcf1", PCF, 64'h1004);
        tick();
        chk64("run_pcf2", PCF, 64'h1008);
        chk64("run_next2", PCNextF, 64'h100C);

        // Learn: the same-cycle lookup sees the pre-update table
        UpdValidE  = 1'b1;
        UpdTakenE  = 1'b1;
        UpdPCE     = 64'h1008;
        UpdTargetE = 64'h2000;
        #1;
        chk64("nobypass_next", PCNextF, 64'h100C);
        chk1("nobypass_pred", PredTakenF, 1'b0);
        tick();
        UpdValidE = 1'b0;
        UpdTakenE = 1'b0;
        fetch("learn", 64'h1008, 64'h2000, 1'b1);

        // Unlearn with stall held: counter 2 -> 1 -> invalid
        StallF    = 1'b1;
        UpdValidE = 1'b1;
        UpdTakenE = 1'b0;
        UpdPCE    = 64'h1008;
        #1;
        chk64("stall_next", PCNextF, 64'h1008);
        chk1("stall_pred", PredTakenF, 1'b0);
        tick();
        UpdValidE = 1'b0;
        StallF    = 1'b0;
        #1;
        chk64("unlearn1_pcf", PCF, 64'h1008);
        chk64("unlearn1_next", PCNextF, 64'h100C);
        chk1("unlearn1_pred", PredTakenF, 1'b0);
        StallF    = 1'b1;
        UpdValidE = 1'b1;
        tick();
        UpdValidE = 1'b0;
        StallF    = 1'b0;
        #1;
        chk64("unlearn2_pcf", PCF, 64'h1008);
        chk64("unlearn2_next", PCNextF, 64'h100C);
        chk1("unlearn2_pred", PredTakenF, 1'b0);

        // Fill all four entries, then replace via round-robin
        upd(64'h10, 64'h110, 1'b1);
        upd(64'h20, 64'h120, 1'b1);
        upd(64'h30, 64'h130, 1'b1);
        upd(64'h40, 64'h140, 1'b1);
        upd(64'h50, 64'h150, 1'b1);
        fetch("repl_10", 64'h10, 64'h110, 1'b0);
        fetch("repl_20", 64'h20, 64'h120, 1'b1);
        fetch("repl_50", 64'h50, 64'h150, 1'b1);
        fetch("repl_40", 64'h40, 64'h140, 1'b1);
        upd(64'h60, 64'h160, 1'b1);
        fetch("rr_20", 64'h20, 64'h120, 1'b0);
        fetch("rr_60", 64'h60, 64'h160, 1'b1);
        fetch("rr_50", 64'h50, 64'h150, 1'b1);
        fetch("rr_30", 64'h30, 64'h130, 1'b1);

        // Saturation and target update: 2 -> 3 -> 3 -> 2
        upd(64'h50, 64'h5550, 1'b1);
        upd(64'h50, 64'h5550, 1'b1);
        upd(64'h50, 64'h5550, 1'b0);
        fetch("sat_50", 64'h50, 64'h5550, 1'b1);

        // Priority: stall masks prediction, redirect beats stall
        StallF = 1'b1;
        #1;
        chk64("prio_stall_next", PCNextF, 64'h50);
        chk1("prio_stall_pred", PredTakenF, 1'b0);
        PCSrcE    = 1'b1;
        PCTargetE = 64'h3000;
        #1;
        chk64("prio_redir_next", PCNextF, 64'h3000);
        chk1("prio_redir_pred", PredTakenF, 1'b0);
        tick();
        PCSrcE    = 1'b0;
        PCTargetE = '0;
        #1;
        chk64("prio_redir_pcf", PCF, 64'h3000);
        chk64("prio_hold_next", PCNextF, 64'h3000);
        tick();
        StallF = 1'b0;
        #1;
        chk64("prio_hold_pcf", PCF, 64'h3000);
        chk64("prio_free_next", PCNextF, 64'h3004);

        // Reset mid-operation discards the concurrent update and clears the table
        UpdValidE  = 1'b1;
        UpdTakenE  = 1'b1;
        UpdPCE     = 64'h3000;
        UpdTargetE = 64'h7000;
        rst        = 1'b1;
        #1;
        chk64("mrst_async_pcf", PCF, 64'h1000);
        tick();
        rst       = 1'b0;
        UpdValidE = 1'b0;
        UpdTakenE = 1'b0;
        #1;
        chk64("mrst_pcf", PCF, 64'h1000);
        chk64("mrst_next", PCNextF, 64'h1004);
        chk1("mrst_pred", PredTakenF, 1'b0);
        fetch("mrst_50", 64'h50, 64'h5550, 1'b0);
        fetch("mrst_3000", 64'h3000, 64'h7000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
